// File: rtl/prog_ctr_fetch.sv
// Program counter and fetch sequencer: steps or branches the instruction address,
// runs the Start/Done launch handshake and counts retired instructions.
//
// state  | meaning
// IDLE   | after reset, waiting for Start; all other inputs ignored
// RUN    | fetching; ProgCtr advances unless stalled or halted
// HALTED | halt retired; ProgCtr/InstCount frozen, Start relaunches
module prog_ctr_fetch #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             Stall,
  input  logic             Branch,
  input  logic             BranchBack,
  input  logic [7:0]       Offset,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, running_d;
  logic             done_q, done_d;

  logic [PC_W-1:0]  offset_ext;
  logic [CNT_W-1:0] cnt_inc;

  assign offset_ext = PC_W'(Offset);
  // Counter sticks at all-ones rather than wrapping.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HALTED: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (Halt) begin
          state_d = HALTED;
          cnt_d   = cnt_inc;
        end else if (!Stall) begin
          cnt_d = cnt_inc;
          if (Branch) begin
            pc_d = BranchBack ? (pc_q - offset_ext) : (pc_q + offset_ext);
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == HALTED);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign ProgCtr   = pc_q;
  assign InstCount = cnt_q;
  assign Running   = running_q;
  assign Done      = done_q;

endmodule
